// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared state encodings and default command bytes for the psram link
//
// Purpose: constants used by both the psram responder and the psram initiator so
// that the two ends agree on the command bytes and on the debug state encoding.
package psram_pkg;

  // Responder state encoding, exported on o_state for on-screen debug.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_WDATA  = 3'd4;
  localparam logic [2:0] ST_RDATA  = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  // Default command bytes.
  localparam logic [7:0] PSRAM_CMD_WRITE = 8'h38;
  localparam logic [7:0] PSRAM_CMD_READ  = 8'hEB;

  // Address bytes carried on the bus, MSB first.
  localparam logic [1:0] PSRAM_LAST_ADDR_BYTE = 2'd2;

endpackage

// File: rtl/psram_mem_bram.sv
// rtl/psram_mem_bram.sv - byte-wide single-port block RAM with registered read
//
// Purpose: backing store of the psram responder. Contents are not reset.
// Ports:
//   clk_i    - clock
//   we_i     - write enable, writes wdata_i to mem[addr_i]
//   addr_i   - byte address
//   wdata_i  - write byte
//   rdata_o  - mem[addr_i] as registered on the previous clock
module psram_mem_bram #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [2**AW];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/psram_responder.sv
// rtl/psram_responder.sv - psram bus responder backed by an internal block RAM
//
// Purpose: decodes write/read transactions from an external initiator whose
// csn/sclk/data are asynchronous to clk_i, and serves them from psram_mem_bram.
// Ports:
//   clk_i        - system clock (sclk must be at most clk_i/4)
//   rstn_i       - asynchronous active-low reset
//   i_psram_csn  - chip select, active low, asynchronous
//   i_psram_sclk - serial clock, asynchronous
//   i_data       - sampled bus byte
//   o_data       - driven bus byte, changes only on sclk falling edges
//   o_data_oe    - bus output enable, high only while serving read data
//   o_busy       - state is not IDLE
//   o_err        - sticky, set by an unknown command byte
//   o_state      - current state encoding
module psram_responder
  import psram_pkg::*;
#(
  parameter int         MEM_AW       = 10,
  parameter int         READ_LATENCY = 6,
  parameter logic [7:0] CMD_WRITE    = PSRAM_CMD_WRITE,
  parameter logic [7:0] CMD_READ     = PSRAM_CMD_READ
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       i_psram_csn,
  input  logic       i_psram_sclk,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_data_oe,
  output logic       o_busy,
  output logic       o_err,
  output logic [2:0] o_state
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_DUMMY =
    (READ_LATENCY > 0) ? CNT_W'(READ_LATENCY - 1) : '0;

  // [0] and [1] form the synchronizer, [2] is the edge-detect history.
  logic [2:0] csn_sync_q;
  logic [2:0] sclk_sync_q;
  // Data goes through the same two stages so it lines up with the sclk edge.
  logic [7:0] data_s1_q;
  logic [7:0] data_s2_q;

  logic [2:0]        state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [1:0]        abyte_q, abyte_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic              is_read_q, is_read_d;
  logic [7:0]        data_q, data_d;
  logic              oe_q, oe_d;
  logic              err_q, err_d;

  logic              csn_s;
  logic              csn_fall;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              mem_we;
  logic [7:0]        mem_rdata;
  logic [MEM_AW+7:0] addr_shift;
  logic [MEM_AW-1:0] addr_inc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      csn_sync_q  <= 3'b111;
      sclk_sync_q <= 3'b000;
      data_s1_q   <= 8'h00;
      data_s2_q   <= 8'h00;
    end else begin
      csn_sync_q  <= {csn_sync_q[1:0], i_psram_csn};
      sclk_sync_q <= {sclk_sync_q[1:0], i_psram_sclk};
      data_s1_q   <= i_data;
      data_s2_q   <= data_s1_q;
    end
  end

  assign csn_s     = csn_sync_q[1];
  assign csn_fall  = ~csn_sync_q[1] & csn_sync_q[2];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];

  // The RAM reads addr_q continuously. addr_q only moves on an sclk edge and
  // edges are at least two clk_i apart, so the byte for the next falling edge
  // has been fetched well before that edge is acted on.
  psram_mem_bram #(
    .AW(MEM_AW)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .addr_i (addr_q),
    .wdata_i(data_s2_q),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    abyte_d    = abyte_q;
    dcnt_d     = dcnt_q;
    is_read_d  = is_read_q;
    data_d     = data_q;
    oe_d       = oe_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    addr_shift = {addr_q, data_s2_q};
    addr_inc   = addr_q + 1'b1;

    // csn high wins over any sclk edge seen in the same cycle.
    if (csn_s) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      abyte_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (csn_fall) begin
            state_d = ST_CMD;
            abyte_d = 2'd0;
            dcnt_d  = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            if (data_s2_q == CMD_WRITE) begin
              is_read_d = 1'b0;
              state_d   = ST_ADDR;
            end else if (data_s2_q == CMD_READ) begin
              is_read_d = 1'b1;
              state_d   = ST_ADDR;
            end else begin
              state_d = ST_IGNORE;
              err_d   = 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            // Shifting whole bytes in and keeping the low bits leaves exactly
            // the low MEM_AW bits of the 24-bit address after the third byte.
            addr_d  = addr_shift[MEM_AW-1:0];
            abyte_d = abyte_q + 2'd1;
            if (abyte_q == PSRAM_LAST_ADDR_BYTE) begin
              abyte_d = 2'd0;
              dcnt_d  = '0;
              if (!is_read_q) begin
                state_d = ST_WDATA;
              end else if (READ_LATENCY == 0) begin
                state_d = ST_RDATA;
              end else begin
                state_d = ST_DUMMY;
              end
            end
          end
        end
        ST_WDATA: begin
          if (sclk_rise) begin
            mem_we = 1'b1;
            addr_d = addr_inc;
          end
        end
        ST_DUMMY: begin
          if (sclk_rise) begin
            if (dcnt_q == LAST_DUMMY) begin
              dcnt_d  = '0;
              state_d = ST_RDATA;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end
        end
        ST_RDATA: begin
          if (sclk_fall) begin
            data_d = mem_rdata;
            oe_d   = 1'b1;
            addr_d = addr_inc;
          end
        end
        default: begin
          // IGNORE: every edge is dropped until csn returns high.
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      abyte_q   <= 2'd0;
      dcnt_q    <= '0;
      is_read_q <= 1'b0;
      data_q    <= 8'h00;
      oe_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      abyte_q   <= abyte_d;
      dcnt_q    <= dcnt_d;
      is_read_q <= is_read_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
      err_q     <= err_d;
    end
  end

  assign o_data    = data_q;
  assign o_data_oe = oe_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_err     = err_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_psram_responder.sv
// tb/tb_psram_responder.sv - randomized self-checking bench for psram_responder
module tb_psram_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int LAT   = 6;

  logic       clk = 1'b0;
  logic       rstn;
  logic       csn;
  logic       sclk;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe;
  logic       busy;
  logic       err;
  logic [2:0] st;

  always #5 clk = ~clk;

  psram_responder #(
    .MEM_AW      (AW),
    .READ_LATENCY(LAT)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .i_psram_csn (csn),
    .i_psram_sclk(sclk),
    .i_data      (din),
    .o_data      (dout),
    .o_data_oe   (oe),
    .o_busy      (busy),
    .o_err       (err),
    .o_state     (st)
  );

  int         n_chk = 0;
  int         n_err = 0;
  int         half  = 4;
  logic [7:0] mem_m [DEPTH];
  logic       err_m = 1'b0;
  logic [7:0] wq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One sclk period: fall with d on the bus, sample outputs just before the rise.
  task automatic sclk_cycle(input logic [7:0] d, input logic [2:0] st_exp, input logic oe_exp,
                            input logic chk_rd, input logic [7:0] rd_exp);
    sclk = 1'b0;
    din  = d;
    repeat (half) @(negedge clk);
    check("state", {29'd0, st}, {29'd0, st_exp});
    check("oe", {31'd0, oe}, {31'd0, oe_exp});
    if (chk_rd) check("rdata", {24'd0, dout}, {24'd0, rd_exp});
    sclk = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic end_xfer();
    sclk = 1'b0;
    repeat (half) @(negedge clk);
    csn = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_state", {29'd0, st}, 32'd0);
    check("idle_oe", {31'd0, oe}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("err", {31'd0, err}, {31'd0, err_m});
  endtask

  // Full transaction; n_addr < 3 aborts after that many address bytes.
  task automatic do_xfer(input logic [7:0] cmd, input logic [23:0] a, input int n_addr, input int n_data);
    int         ad;
    logic [7:0] b;
    logic       bad;
    bad  = (cmd != 8'h38) && (cmd != 8'hEB);
    sclk = 1'b0;
    csn  = 1'b0;
    repeat (2) @(negedge clk);
    sclk_cycle(cmd, 3'd1, 1'b0, 1'b0, 8'h00);
    if (bad) begin
      err_m = 1'b1;
      for (int i = 0; i < n_data; i++) sclk_cycle(8'($urandom), 3'd6, 1'b0, 1'b0, 8'h00);
    end else begin
      for (int i = 0; i < n_addr; i++) sclk_cycle(a[23-8*i -: 8], 3'd2, 1'b0, 1'b0, 8'h00);
      if (n_addr == 3) begin
        ad = int'(a[AW-1:0]);
        if (cmd == 8'hEB) begin
          for (int i = 0; i < LAT; i++) sclk_cycle(8'($urandom), 3'd3, 1'b0, 1'b0, 8'h00);
          for (int k = 0; k < n_data; k++) begin
            sclk_cycle(8'($urandom), 3'd5, 1'b1, 1'b1, mem_m[ad]);
            ad = (ad + 1) % DEPTH;
          end
        end else begin
          for (int k = 0; k < n_data; k++) begin
            b = (wq.size() > 0) ? wq.pop_front() : 8'($urandom);
            sclk_cycle(b, 3'd4, 1'b0, 1'b0, 8'h00);
            mem_m[ad] = b;
            ad = (ad + 1) % DEPTH;
          end
        end
      end
    end
    end_xfer();
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] c;
    logic [7:0] keep;
    rstn = 1'b0;
    csn  = 1'b1;
    sclk = 1'b0;
    din  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_state", {29'd0, st}, 32'd0);
    check("rst_oe", {31'd0, oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_data", {24'd0, dout}, 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_state", {29'd0, st}, 32'd0);

    // Fill the whole memory so every later read has a known expectation.
    do_xfer(8'h38, 24'h000000, 3, DEPTH);

    wq = '{8'h87, 8'h65};
    do_xfer(8'h38, 24'hABCDEF, 3, 2);
    do_xfer(8'hEB, 24'hABCDEF, 3, 2);
    check("mem_1ef", {24'd0, mem_m[10'h1EF]}, 32'h87);

    wq = '{8'h11, 8'h22};
    do_xfer(8'h38, 24'h0003FF, 3, 2);
    do_xfer(8'hEB, 24'h0003FF, 3, 2);

    // csn rising together with sclk: the byte on that edge must not land.
    half = 4;
    csn  = 1'b0;
    repeat (2) @(negedge clk);
    sclk_cycle(8'h38, 3'd1, 1'b0, 1'b0, 8'h00);
    sclk_cycle(8'h00, 3'd2, 1'b0, 1'b0, 8'h00);
    sclk_cycle(8'h01, 3'd2, 1'b0, 1'b0, 8'h00);
    sclk_cycle(8'h00, 3'd2, 1'b0, 1'b0, 8'h00);
    sclk_cycle(8'h5A, 3'd4, 1'b0, 1'b0, 8'h00);
    mem_m[10'h100] = 8'h5A;
    keep = ~mem_m[10'h101];
    sclk = 1'b0;
    din  = keep;
    repeat (half) @(negedge clk);
    csn  = 1'b1;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    check("prio_state", {29'd0, st}, 32'd0);
    do_xfer(8'hEB, 24'h000100, 3, 2);

    do_xfer(8'hEB, 24'h0001EF, 2, 0);
    do_xfer(8'hEB, 24'h0001EF, 3, 1);

    for (int t = 0; t < 24; t++) begin
      int          kind;
      int          n;
      logic [23:0] a;
      half = $urandom_range(6, 4);
      kind = $urandom_range(9, 0);
      n    = $urandom_range(6, 1);
      a    = 24'($urandom);
      if (kind == 0) begin
        c = 8'($urandom);
        if (c == 8'h38 || c == 8'hEB) c = c ^ 8'h01;
        do_xfer(c, a, 0, n);
      end else if (kind == 1) begin
        do_xfer(($urandom_range(1, 0) == 1) ? 8'hEB : 8'h38, a, $urandom_range(2, 0), 0);
      end else if (kind < 6) begin
        do_xfer(8'h38, a, 3, n);
      end else begin
        do_xfer(8'hEB, a, 3, n);
      end
    end

    half = 4;
    do_xfer(8'h12, 24'h000000, 0, 4);
    do_xfer(8'hEB, 24'h0001EF, 3, 2);
    do_xfer(8'hEB, 24'h0003FF, 3, 2);

    // Reset in the middle of a read burst.
    csn = 1'b0;
    repeat (2) @(negedge clk);
    sclk_cycle(8'hEB, 3'd1, 1'b0, 1'b0, 8'h00);
    sclk_cycle(8'h00, 3'd2, 1'b0, 1'b0, 8'h00);
    sclk_cycle(8'h01, 3'd2, 1'b0, 1'b0, 8'h00);
    sclk_cycle(8'hEF, 3'd2, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < LAT; i++) sclk_cycle(8'h00, 3'd3, 1'b0, 1'b0, 8'h00);
    sclk_cycle(8'h00, 3'd5, 1'b1, 1'b1, mem_m[10'h1EF]);
    sclk = 1'b0;
    repeat (half) @(negedge clk);
    check("pre_rst_oe", {31'd0, oe}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_oe", {31'd0, oe}, 32'd0);
    check("async_rst_state", {29'd0, st}, 32'd0);
    check("async_rst_err", {31'd0, err}, 32'd0);
    check("async_rst_data", {24'd0, dout}, 32'd0);
    err_m = 1'b0;
    csn   = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("resume_state", {29'd0, st}, 32'd0);
    do_xfer(8'hEB, 24'h0001EF, 3, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
